bsg_counter_clear_up_down_max_val: RTL

- Parametrised successor of the clear/up counter family: adds down-count, multi-unit steps, parallel load, and a saturate-or-wrap mode.
- Adds terminal-value indicators and sticky overflow/underflow flags.
- Used for credit tracking, FIFO occupancy, and event counting where one block must both grant and return units in the same cycle.

---
 rtl/bsg_counter_clear_up_down_max_val.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bsg_counter_clear_up_down_max_val.sv
// bsg_counter_clear_up_down_max_val
//
// Up/down counter over 0..max_val_p with multi-unit steps, parallel load,
// clear, and either saturating or modulo (max_val_p+1) wrapping behaviour.
// Terminal-value indicators follow the registered count combinationally.
// The overflow/underflow flags are sticky. Only clear or reset zeroes them.
//
// Ports
//   clk_i        clock, rising edge
//   reset_n_i    synchronous active-low reset (count <= init_val_p, flags <= 0)
//   clear_i      zero the base count (and sticky flags); same-cycle step still applied
//   load_i       load min(load_val_i, max_val_p); step ignored, flags held
//   load_val_i   load value
//   up_i         units to add this cycle
//   down_i       units to subtract this cycle
//   count_o      registered count
//   at_max_o     count_o == max_val_p
//   at_zero_o    count_o == 0
//   overflow_o   sticky: a step went above max_val_p
//   underflow_o  sticky: a step went below 0

module bsg_counter_clear_up_down_max_val #(
    parameter int max_val_p    = 128,
    parameter int init_val_p   = 0,
    parameter int step_width_p = 1,
    parameter int wrap_p       = 0,
    localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [ptr_width_lp-1:0] load_val_i,
    input  logic [step_width_p-1:0] up_i,
    input  logic [step_width_p-1:0] down_i,
    output logic [ptr_width_lp-1:0] count_o,
    output logic                    at_max_o,
    output logic                    at_zero_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    // Two extra bits: one for the sign, one so base + up cannot overflow.
    localparam int sum_width_lp = ptr_width_lp + 2;

    localparam logic [ptr_width_lp-1:0]        max_cnt_lp  = ptr_width_lp'(max_val_p);
    localparam logic [ptr_width_lp-1:0]        init_cnt_lp = ptr_width_lp'(init_val_p);
    localparam logic signed [sum_width_lp-1:0] max_sum_lp  = sum_width_lp'(max_val_p);
    localparam logic signed [sum_width_lp-1:0] modulus_lp  = sum_width_lp'(max_val_p + 1);

    if (init_val_p > max_val_p) begin : g_bad_init
        $error("init_val_p (%0d) exceeds max_val_p (%0d)", init_val_p, max_val_p);
    end

    if (((2 ** step_width_p) - 1) > max_val_p) begin : g_bad_step
        $error("step_width_p (%0d) allows steps larger than max_val_p (%0d)",
               step_width_p, max_val_p);
    end

    logic [ptr_width_lp-1:0]        r_count;
    logic                           r_overflow;
    logic                           r_underflow;

    logic signed [sum_width_lp-1:0] w_base;
    logic signed [sum_width_lp-1:0] w_up;
    logic signed [sum_width_lp-1:0] w_down;
    logic signed [sum_width_lp-1:0] w_sum;
    logic                           w_over;
    logic                           w_under;
    logic [ptr_width_lp-1:0]        w_step_cnt;
    logic [ptr_width_lp-1:0]        w_load_cnt;

    assign w_base  = clear_i ? '0 : {2'b00, r_count};
    assign w_up    = {{(sum_width_lp - step_width_p){1'b0}}, up_i};
    assign w_down  = {{(sum_width_lp - step_width_p){1'b0}}, down_i};
    assign w_sum   = w_base + w_up - w_down;
    assign w_over  = w_sum > max_sum_lp;
    assign w_under = w_sum[sum_width_lp-1];

    // Steps never exceed max_val_p, so a single +/- modulus always lands in range.
    always_comb begin
        w_step_cnt = w_sum[ptr_width_lp-1:0];
        if (w_over) begin
            if (wrap_p != 0) begin
                w_step_cnt = ptr_width_lp'(w_sum - modulus_lp);
            end else begin
                w_step_cnt = max_cnt_lp;
            end
        end else if (w_under) begin
            if (wrap_p != 0) begin
                w_step_cnt = ptr_width_lp'(w_sum + modulus_lp);
            end else begin
                w_step_cnt = '0;
            end
        end
    end

    assign w_load_cnt = (load_val_i > max_cnt_lp) ? max_cnt_lp : load_val_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count     <= init_cnt_lp;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (load_i) begin
            r_count     <= w_load_cnt;
        end else begin
            r_count     <= w_step_cnt;
            // Clear drops the old flag, but a same-cycle event sets it again.
            r_overflow  <= (r_overflow  & ~clear_i) | w_over;
            r_underflow <= (r_underflow & ~clear_i) | w_under;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (r_count <= max_cnt_lp)
                else $error("count %0d exceeds max_val_p %0d", r_count, max_val_p);
        end
    end

    assign count_o     = r_count;
    assign at_max_o    = (r_count == max_cnt_lp);
    assign at_zero_o   = (r_count == '0);
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule
